sn_accum_bank: RTL and testbench
================================

// Module: sn_accum_bank
// PURPOSE
//  Parametrised bank of N_CH saturating up/down counters that convert stochastic bitstreams
//  (output of the SN generator/MUX FSM) back to binary over a start-framed window.
//  Adds per-lane saturation flags, bipolar/unipolar mode, abort, a window-length count and a
//  registered result with a one-cycle valid strobe. Sits after the SN generator inside MVM.
// PARAMETERS
//  N_CH   4  number of lanes (stochastic bitstreams accumulated in parallel)
//  CNT_W  8  lane counter width, two's complement signed
//  LEN_W  8  width of window-length counter (saturates at 2**LEN_W-1)
// PORTS
//  i_clk_udc       in   1            clock, rising edge
//  i_rst_udc       in   1            reset, asynchronous, active-high
//  i_start_udc     in   1            window active; accumulate every cycle it is high
//  i_abort_udc     in   1            synchronous abort of current window
//  i_mode_udc      in   1            0 = bipolar (bit1:+1, bit0:-1), 1 = unipolar (bit1:+1, bit0:+0)
//  i_sn_bit_udc    in   N_CH         one stochastic bit per lane
//  o_acc_result    out  N_CH*CNT_W   latched lane results, lane k at [k*CNT_W +: CNT_W], signed
//  o_sat_udc       out  N_CH         per-lane flag: lane saturated at least once in window
//  o_len_udc       out  LEN_W        number of accumulated cycles in latched window
//  o_valid_udc     out  1            one-cycle pulse when o_acc_result/o_sat/o_len update
//  o_busy_udc      out  1            high while state == ACC
// BEHAVIOUR
//  Reset: state IDLE; all lane counters, o_acc_result, o_sat_udc, o_len_udc = 0; o_valid_udc = 0.
//  FSM (registered state):
//   IDLE: i_start_udc=1 -> ACC; lanes load 0 + contribution of current bit, len = 1, sat cleared.
//   ACC : i_abort_udc=1 -> IDLE, lanes/len/sat zeroed, NO valid, outputs unchanged (abort wins).
//         i_start_udc=1 -> stay, accumulate; i_start_udc=0 -> DONE.
//   DONE: o_valid_udc=1 this cycle; output regs already hold the window result.
//         i_start_udc=1 -> ACC with fresh window (as from IDLE); else -> IDLE.
//  Latch: on ACC->DONE transition edge, o_acc_result/o_sat_udc/o_len_udc <= lane/len state.
//  Latency: result visible and o_valid_udc high exactly 1 cycle after first cycle with start=0.
//  Mode is sampled every cycle; changing it mid-window is legal (per-cycle contribution rule).
//  Arithmetic: signed CNT_W; saturate at +2**(CNT_W-1)-1 and -2**(CNT_W-1), never wrap.
//   An increment at max or decrement at min holds value and sets that lane's sat flag.
//  Length counter saturates at 2**LEN_W-1 (no flag).
//  Outside ACC, i_sn_bit_udc is ignored. i_abort_udc in IDLE/DONE is ignored.
//  Results hold between valid pulses; reset mid-window clears everything immediately.
// STRUCTURE
//  Package sn_pkg: typedef enum logic [1:0] {UDC_IDLE, UDC_ACC, UDC_DONE} udc_state_e;
//   typedef enum logic {SN_BIPOLAR=1'b0, SN_UNIPOLAR=1'b1} sn_mode_e; shared with SN generator.
//  Sub-module sn_udc_lane (one saturating lane: clear/load/step inputs, value + sat outputs),
//  instantiated N_CH times via generate; FSM, len counter and output regs in sn_accum_bank.
// TESTING
//  1 Bipolar, lane0 bits 1,1,0,1 then start=0 -> o_acc_result lane0 = +2, o_len=4, valid 1 cycle.
//  2 Unipolar, lane1 all 1 for 10 cycles, lane2 all 0 -> lane1 = 10, lane2 = 0, sat = 0.
//  3 CNT_W=8 bipolar, lane3 all 1 for 200 cycles -> lane3 = 127, o_sat[3]=1; all 0 -> -128, sat.
//  4 Abort after 5 cycles of ACC -> no valid, previous result unchanged, next window starts at 0.
//  5 start high in DONE cycle -> valid pulses once, new window len counts from 1, no lost bit.
//  6 Assert i_rst_udc mid-ACC (async, off-edge) -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/sn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sn_pkg
//  Description : Shared types for the stochastic-number datapath: the
//                up/down-counter FSM states, the bitstream mode and a helper
//                that maps one stochastic bit to a counter step.
//  Revision    : 1.0  initial release
// ============================================================================
package sn_pkg;

    typedef enum logic [1:0] {
        UDC_IDLE = 2'd0,
        UDC_ACC  = 2'd1,
        UDC_DONE = 2'd2
    } udc_state_e;

    typedef enum logic {
        SN_BIPOLAR  = 1'b0,
        SN_UNIPOLAR = 1'b1
    } sn_mode_e;

    typedef struct packed {
        logic up;
        logic dn;
    } sn_step_t;

    // Bit 1 always counts up; bit 0 counts down only for bipolar streams.
    function automatic sn_step_t sn_decode(input logic sn_bit, input sn_mode_e mode);
        sn_step_t s;
        s.up = sn_bit;
        s.dn = ~sn_bit & (mode == SN_BIPOLAR);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sn_udc_lane.sv
`default_nettype none
// ============================================================================
//  Module      : sn_udc_lane
//  Description : One saturating signed up/down counter lane. Clear zeroes
//                the lane, load starts a fresh window with the current bit's
//                contribution, step accumulates it with saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module sn_udc_lane
    import sn_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                    i_clk_udc,
    input  logic                    i_rst_udc,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic                    i_step,
    input  logic                    i_sn_bit,
    input  sn_mode_e                i_mode,
    output logic signed [CNT_W-1:0] o_value,
    output logic                    o_sat
);

    localparam logic signed [CNT_W-1:0] c_max  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] c_min  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [CNT_W-1:0] c_mone = {CNT_W{1'b1}};

    sn_step_t                w_step;
    logic signed [CNT_W-1:0] r_value;
    logic                    r_sat;

    assign w_step  = sn_decode(i_sn_bit, i_mode);
    assign o_value = r_value;
    assign o_sat   = r_sat;

    // Lane counter: clear > load > saturating step; holds otherwise.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            r_value <= '0;
            r_sat   <= 1'b0;
        end else if (i_clear) begin
            r_value <= '0;
            r_sat   <= 1'b0;
        end else if (i_load) begin
            r_sat <= 1'b0;
            if (w_step.up)
                r_value <= c_one;
            else if (w_step.dn)
                r_value <= c_mone;
            else
                r_value <= '0;
        end else if (i_step) begin
            if (w_step.up) begin
                if (r_value == c_max)
                    r_sat <= 1'b1;
                else
                    r_value <= r_value + c_one;
            end else if (w_step.dn) begin
                if (r_value == c_min)
                    r_sat <= 1'b1;
                else
                    r_value <= r_value - c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sn_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sn_accum_bank
//  Description : Bank of N_CH saturating up/down counters converting
//                stochastic bitstreams back to binary over a start-framed
//                window, with abort, window length, sat flags and a
//                registered result qualified by a one-cycle valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sn_accum_bank
    import sn_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic                    i_clk_udc,
    input  logic                    i_rst_udc,
    input  logic                    i_start_udc,
    input  logic                    i_abort_udc,
    input  logic                    i_mode_udc,
    input  logic [N_CH-1:0]         i_sn_bit_udc,
    output logic [N_CH*CNT_W-1:0]   o_acc_result,
    output logic [N_CH-1:0]         o_sat_udc,
    output logic [LEN_W-1:0]        o_len_udc,
    output logic                    o_valid_udc,
    output logic                    o_busy_udc
);

    localparam logic [LEN_W-1:0] c_len_max = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};

    udc_state_e              r_state;
    logic                    r_valid;
    logic                    r_busy;
    logic [LEN_W-1:0]        r_len;
    logic [N_CH*CNT_W-1:0]   r_acc_result;
    logic [N_CH-1:0]         r_sat_out;
    logic [LEN_W-1:0]        r_len_out;

    logic                    w_load;
    logic                    w_clear;
    logic                    w_step;
    logic [N_CH*CNT_W-1:0]   w_lane_flat;
    logic [N_CH-1:0]         w_lane_sat;
    sn_mode_e                w_mode;

    assign w_mode = sn_mode_e'(i_mode_udc);

    // Lane control decoded from the registered state; abort has priority.
    always_comb begin
        w_load  = 1'b0;
        w_clear = 1'b0;
        w_step  = 1'b0;
        case (r_state)
            UDC_IDLE, UDC_DONE: w_load = i_start_udc;
            UDC_ACC: begin
                w_clear = i_abort_udc;
                w_step  = ~i_abort_udc & i_start_udc;
            end
            default: ;
        endcase
    end

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            logic signed [CNT_W-1:0] w_val;

            sn_udc_lane #(
                .CNT_W (CNT_W)
            ) u_lane (
                .i_clk_udc (i_clk_udc),
                .i_rst_udc (i_rst_udc),
                .i_clear   (w_clear),
                .i_load    (w_load),
                .i_step    (w_step),
                .i_sn_bit  (i_sn_bit_udc[k]),
                .i_mode    (w_mode),
                .o_value   (w_val),
                .o_sat     (w_lane_sat[k])
            );

            assign w_lane_flat[k*CNT_W +: CNT_W] = w_val;
        end
    endgenerate

    // Window FSM with length counter and the result/flag output registers.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            r_state      <= UDC_IDLE;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_len        <= '0;
            r_acc_result <= '0;
            r_sat_out    <= '0;
            r_len_out    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                UDC_IDLE, UDC_DONE: begin
                    if (i_start_udc) begin
                        r_state <= UDC_ACC;
                        r_busy  <= 1'b1;
                        r_len   <= c_len_one;
                    end else begin
                        r_state <= UDC_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                UDC_ACC: begin
                    if (i_abort_udc) begin
                        r_state <= UDC_IDLE;
                        r_busy  <= 1'b0;
                        r_len   <= '0;
                    end else if (i_start_udc) begin
                        if (r_len != c_len_max)
                            r_len <= r_len + c_len_one;
                    end else begin
                        r_state      <= UDC_DONE;
                        r_busy       <= 1'b0;
                        r_valid      <= 1'b1;
                        r_acc_result <= w_lane_flat;
                        r_sat_out    <= w_lane_sat;
                        r_len_out    <= r_len;
                    end
                end
                default: begin
                    r_state <= UDC_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_acc_result = r_acc_result;
    assign o_sat_udc    = r_sat_out;
    assign o_len_udc    = r_len_out;
    assign o_valid_udc  = r_valid;
    assign o_busy_udc   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sn_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sn_accum_bank
//  Description : Self-checking bench for sn_accum_bank: a vector table for
//                the basic bipolar window, directed corner sequences and a
//                randomized run against a window-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sn_accum_bank;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int LEN_W = 8;
    localparam int MAXV  = 127;
    localparam int MINV  = -128;
    localparam int LMAX  = 255;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  abort_i;
    logic                  mode;
    logic [N_CH-1:0]       bits;
    logic [N_CH*CNT_W-1:0] acc_result;
    logic [N_CH-1:0]       sat;
    logic [LEN_W-1:0]      len;
    logic                  valid;
    logic                  busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: window contents and latched results as plain integers.
    int m_acc[N_CH];
    bit m_sat[N_CH];
    int m_len;
    bit m_inwin;
    bit m_valid;
    int m_out_acc[N_CH];
    bit m_out_sat[N_CH];
    int m_out_len;

    sn_accum_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .i_clk_udc    (clk),
        .i_rst_udc    (rst),
        .i_start_udc  (start),
        .i_abort_udc  (abort_i),
        .i_mode_udc   (mode),
        .i_sn_bit_udc (bits),
        .o_acc_result (acc_result),
        .o_sat_udc    (sat),
        .o_len_udc    (len),
        .o_valid_udc  (valid),
        .o_busy_udc   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_acc[k] = 0; m_sat[k] = 0; m_out_acc[k] = 0; m_out_sat[k] = 0;
        end
        m_len = 0; m_inwin = 0; m_valid = 0; m_out_len = 0;
    endtask

    function automatic int contrib(input logic b, input logic md);
        if (b) return 1;
        return md ? 0 : -1;
    endfunction

    // One clock of the window rules applied to the inputs present at the edge.
    task automatic model_step(input logic s, input logic a, input logic md, input logic [N_CH-1:0] b);
        m_valid = 0;
        if (m_inwin) begin
            if (a) begin
                m_inwin = 0; m_len = 0;
                for (int k = 0; k < N_CH; k++) begin m_acc[k] = 0; m_sat[k] = 0; end
            end else if (s) begin
                if (m_len < LMAX) m_len++;
                for (int k = 0; k < N_CH; k++) begin
                    m_acc[k] += contrib(b[k], md);
                    if (m_acc[k] > MAXV) begin m_acc[k] = MAXV; m_sat[k] = 1; end
                    if (m_acc[k] < MINV) begin m_acc[k] = MINV; m_sat[k] = 1; end
                end
            end else begin
                m_inwin = 0; m_valid = 1; m_out_len = m_len;
                for (int k = 0; k < N_CH; k++) begin
                    m_out_acc[k] = m_acc[k]; m_out_sat[k] = m_sat[k];
                end
            end
        end else if (s) begin
            m_inwin = 1; m_len = 1;
            for (int k = 0; k < N_CH; k++) begin
                m_acc[k] = contrib(b[k], md); m_sat[k] = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [N_CH*CNT_W-1:0] e_acc;
        logic [N_CH-1:0]       e_sat;
        logic [CNT_W-1:0]      lane;
        for (int k = 0; k < N_CH; k++) begin
            lane = m_out_acc[k][CNT_W-1:0];
            e_acc[k*CNT_W +: CNT_W] = lane;
            e_sat[k] = m_out_sat[k];
        end
        chk({tag, ".result"}, 64'(acc_result), 64'(e_acc));
        chk({tag, ".sat"},    64'(sat),        64'(e_sat));
        chk({tag, ".len"},    64'(len),        64'(m_out_len));
        chk({tag, ".valid"},  64'(valid),      64'(m_valid));
        chk({tag, ".busy"},   64'(busy),       64'(m_inwin));
    endtask

    task automatic cycle(input logic s, input logic a, input logic md, input logic [N_CH-1:0] b, input string tag);
        start = s; abort_i = a; mode = md; bits = b;
        @(posedge clk);
        model_step(s, a, md, b);
        #1;
        check_model(tag);
    endtask

    function automatic int lane_of(input logic [N_CH*CNT_W-1:0] v, input int k);
        logic signed [CNT_W-1:0] x;
        x = v[k*CNT_W +: CNT_W];
        return int'(x);
    endfunction

    typedef struct {
        logic            start;
        logic            abort;
        logic            mode;
        logic [N_CH-1:0] bits;
        logic            exp_valid;
        logic            exp_busy;
        int              exp_len;
        int              exp_lane0;
    } vec_t;

    vec_t tbl[7];
    logic [N_CH*CNT_W-1:0] saved_acc;
    logic [LEN_W-1:0]      saved_len;
    int                    vcount;

    initial begin
        rst = 1'b1; start = 0; abort_i = 0; mode = 0; bits = '0;
        model_reset();
        #12;
        chk("reset.result", 64'(acc_result), 64'd0);
        chk("reset.sat",    64'(sat),        64'd0);
        chk("reset.len",    64'(len),        64'd0);
        chk("reset.valid",  64'(valid),      64'd0);
        chk("reset.busy",   64'(busy),       64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Bipolar lane0 bits 1,1,0,1 -> +2 over 4 cycles, valid for exactly one cycle.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4, 2};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4, 2};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4, 2};
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].start, tbl[i].abort, tbl[i].mode, tbl[i].bits, "tbl");
            chk("tbl.valid", 64'(valid), 64'(tbl[i].exp_valid));
            chk("tbl.busy",  64'(busy),  64'(tbl[i].exp_busy));
            chk("tbl.len",   64'(len),   64'(tbl[i].exp_len));
            chk("tbl.lane0", 64'(lane_of(acc_result, 0)), 64'(tbl[i].exp_lane0));
        end
        chk("tbl.lane1", 64'(lane_of(acc_result, 1)), 64'(-4));

        // Unipolar: lane1 all ones for 10 cycles, lane2 all zeros.
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 4'b0010, "unip");
        cycle(0, 0, 1, 4'b0000, "unip");
        chk("unip.lane1", 64'(lane_of(acc_result, 1)), 64'd10);
        chk("unip.lane2", 64'(lane_of(acc_result, 2)), 64'd0);
        chk("unip.sat",   64'(sat), 64'd0);
        cycle(0, 0, 1, 4'b0000, "unip");

        // Bipolar saturation high on lane3, then low on all lanes with len saturating.
        for (int i = 0; i < 200; i++) cycle(1, 0, 0, 4'b1000, "sathi");
        cycle(0, 0, 0, 4'b0000, "sathi");
        chk("sathi.lane3", 64'(lane_of(acc_result, 3)), 64'd127);
        chk("sathi.sat3",  64'(sat[3]), 64'd1);
        chk("sathi.len",   64'(len), 64'd200);
        cycle(0, 0, 0, 4'b0000, "sathi");
        for (int i = 0; i < 300; i++) cycle(1, 0, 0, 4'b0000, "satlo");
        cycle(0, 0, 0, 4'b0000, "satlo");
        chk("satlo.lane3", 64'(lane_of(acc_result, 3)), 64'(-128));
        chk("satlo.sat",   64'(sat), 64'hf);
        chk("satlo.len",   64'(len), 64'd255);
        cycle(0, 0, 0, 4'b0000, "satlo");

        // Abort after 5 accumulating cycles: no valid, results kept, next window from 0.
        saved_acc = acc_result; saved_len = len;
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 4'b1111, "abort");
        cycle(1, 1, 0, 4'b1111, "abort");
        chk("abort.valid", 64'(valid), 64'd0);
        chk("abort.busy",  64'(busy),  64'd0);
        chk("abort.hold",  64'(acc_result), 64'(saved_acc));
        chk("abort.len",   64'(len), 64'(saved_len));
        cycle(1, 0, 0, 4'b0101, "abort");
        cycle(0, 0, 0, 4'b0000, "abort");
        chk("abort.new0",  64'(lane_of(acc_result, 0)), 64'd1);
        chk("abort.new1",  64'(lane_of(acc_result, 1)), 64'(-1));
        chk("abort.nlen",  64'(len), 64'd1);
        chk("abort.nsat",  64'(sat), 64'd0);

        // Start held high in the DONE cycle: back-to-back windows, first bit kept.
        vcount = 0;
        cycle(0, 0, 0, 4'b0000, "b2b");
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 4'b0011, "b2b");
        cycle(0, 0, 0, 4'b0000, "b2b");
        vcount += int'(valid);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 4'b1110, "b2b");
            vcount += int'(valid);
        end
        chk("b2b.vcount", 64'(vcount), 64'd1);
        cycle(0, 0, 1, 4'b0000, "b2b");
        chk("b2b.len",   64'(len), 64'd3);
        chk("b2b.lane3", 64'(lane_of(acc_result, 3)), 64'd3);
        chk("b2b.lane0", 64'(lane_of(acc_result, 0)), 64'd0);

        // Randomized windows against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                  1'($urandom), 4'($urandom), "rand");
        end

        // Asynchronous reset mid-window, applied between clock edges.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 4'b1010, "arst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.result", 64'(acc_result), 64'd0);
        chk("arst.sat",    64'(sat),        64'd0);
        chk("arst.len",    64'(len),        64'd0);
        chk("arst.valid",  64'(valid),      64'd0);
        chk("arst.busy",   64'(busy),       64'd0);
        start = 0;
        #1 rst = 1'b0;
        cycle(0, 0, 0, 4'b1111, "arst");
        cycle(1, 0, 0, 4'b1111, "arst");
        cycle(0, 0, 0, 4'b0000, "arst");
        chk("arst.newlen", 64'(len), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
